alarm_timer_unit: RTL and testbench
===================================

# alarm_timer_unit

Countdown timer stage sitting between the 1 Hz timebase and the alarm control unit. Consumes the control unit's EN_STOP (alarm ringing) and EN_SNZ (snooze in progress) enables, counts whole seconds, and returns the C0 (ring timeout reached) and CS0 (snooze period expired) status flags that the control unit uses for its transitions. It also exports seconds-remaining for the display path.

## Interface
- RING_SECONDS, 60: ring duration in seconds before auto-timeout
- SNZ_SECONDS, 300: snooze period in seconds
- CNT_W, 9: counter width; must satisfy 2^CNT_W > max(RING_SECONDS, SNZ_SECONDS)
- MAX_SNOOZE, 3: snooze periods allowed per alarm event (used only with SNOOZE_LIMIT_EN)
- Clk  in  1  system clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high reset
- Tick  in  1  one-Clk-wide pulse, once per second
- EN_STOP  in  1  from control unit; high while the alarm is ringing
- EN_SNZ  in  1  from control unit; high while a snooze period runs
- C0  out  1  ring counter at zero while ringing
- CS0  out  1  snooze counter at zero while snoozing
- Secs_Left  out  CNT_W  active counter value; 0 in IDLE
- Snz_Limit  out  1  snooze allowance exhausted

## Operation
- FSM states: IDLE, RING, RING_TO, SNOOZE, SNZ_DONE.
- IDLE: both counters held at their load values. EN_SNZ -> SNOOZE. Else EN_STOP -> RING.
- RING: each Tick decrements ring counter. Reaching 0 -> RING_TO. EN_SNZ -> SNOOZE. EN_STOP low -> IDLE.
- RING_TO: C0=1. EN_SNZ -> SNOOZE. EN_STOP low -> IDLE.
- SNOOZE: each Tick decrements snooze counter. Reaching 0 -> SNZ_DONE. EN_SNZ low -> RING if EN_STOP, else IDLE.
- SNZ_DONE: CS0=1. Exits on EN_SNZ low, using the same rule as SNOOZE.
- EN_SNZ has priority over EN_STOP when both are high.
- Counter loading:
  - Ring counter reloads RING_SECONDS on every entry to RING from IDLE or SNOOZE/SNZ_DONE.
  - Snooze counter reloads SNZ_SECONDS on every entry to SNOOZE.
- Counters saturate at 0. A Tick at 0 does nothing; there is no wrap.
- A Tick arriving in the same cycle as a state entry is ignored, because the load wins.
- Secs_Left shows the ring counter in RING/RING_TO, the snooze counter in SNOOZE/SNZ_DONE, and 0 in IDLE.

## Timing
- All outputs are registered.
- Reset values: C0=0, CS0=0, Secs_Left=0, Snz_Limit=0, state=IDLE, counters loaded.
- Tick that brings a counter to 0 in cycle n: C0 or CS0 rises in cycle n+1.
- Enable change in cycle n: state and outputs update in cycle n+1; C0/CS0 clear in that cycle on exit.
- Reset asserted mid-count: the next cycle matches the reset values, and any partial count is discarded.
- RING_SECONDS=0 or SNZ_SECONDS=0: the flag asserts one cycle after entry.

## Configuration
- SNOOZE_LIMIT_EN defined:
  - A snooze-entry counter increments on each SNOOZE entry.
  - It clears on Reset, or when EN_STOP falls while EN_SNZ is low (user stop).
  - Once MAX_SNOOZE entries have completed, a further entry loads 0 into the snooze counter, so CS0 asserts one cycle after entry.
  - Snz_Limit=1 from that point until the counter clears.
- SNOOZE_LIMIT_EN undefined: unlimited snoozes, Snz_Limit tied to 0, and no entry counter is built.

## Structure
- Shared package alarm_pkg holds:
  - the state enum for IDLE/RING/RING_TO/SNOOZE/SNZ_DONE;
  - default constants RING_SECONDS_DEF, SNZ_SECONDS_DEF, MAX_SNOOZE_DEF.
- Sub-module sec_down_counter (ports: load, load_val, dec, value, zero) is instantiated twice, for ring and snooze.
- FSM, output registers and the optional limit counter live in the top.

## Test plan
Bench uses RING_SECONDS=3, SNZ_SECONDS=5, MAX_SNOOZE=2, and a Tick every 4 Clk.
- Reset held 2 cycles, all inputs 0 -> C0=0, CS0=0, Secs_Left=0, Snz_Limit=0.
- EN_STOP=1 for 20 cycles -> Secs_Left goes 3,2,1,0; C0 rises 1 cycle after the 3rd Tick; EN_STOP=0 -> C0=0 next cycle.
- Ring, then EN_SNZ=1 while EN_STOP=1 -> Secs_Left=5, C0=0; after 5 Ticks CS0=1; EN_SNZ=0 -> RING with Secs_Left=3.
- EN_SNZ and Tick rise in the same cycle -> Secs_Left=5, not 4.
- Reset asserted with the snooze counter at 2 -> next cycle all outputs 0, state IDLE.
- With SNOOZE_LIMIT_EN, three snooze entries without a user stop -> third entry gives CS0=1 one cycle after entry and Snz_Limit=1; EN_STOP falling with EN_SNZ=0 -> Snz_Limit=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm timer stage.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RING     = 3'd1,
    ST_RING_TO  = 3'd2,
    ST_SNOOZE   = 3'd3,
    ST_SNZ_DONE = 3'd4
  } alarm_state_t;

  localparam int RING_SECONDS_DEF = 60;
  localparam int SNZ_SECONDS_DEF  = 300;
  localparam int MAX_SNOOZE_DEF   = 3;

endpackage

// File: rtl/sec_down_counter.sv
// Saturating seconds down-counter; load has priority over decrement.
module sec_down_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk) begin
    if (load) begin
      value <= load_val;
    end else if (dec && !zero) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/alarm_timer_unit.sv
// Ring/snooze countdown timer between the 1 Hz timebase and the alarm control unit.
// Optional snooze allowance limit is built when SNOOZE_LIMIT_EN is defined.
//
// state       | meaning
// IDLE        | no alarm activity, both counters held at their load values
// RING        | alarm ringing, ring counter counting down
// RING_TO     | ring timeout reached, C0 high
// SNOOZE      | snooze period running, snooze counter counting down
// SNZ_DONE    | snooze period expired, CS0 high
module alarm_timer_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS = RING_SECONDS_DEF,
  parameter int SNZ_SECONDS  = SNZ_SECONDS_DEF,
  parameter int CNT_W        = 9,
  parameter int MAX_SNOOZE   = MAX_SNOOZE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             EN_STOP,
  input  logic             EN_SNZ,
  output logic             C0,
  output logic             CS0,
  output logic [CNT_W-1:0] Secs_Left,
  output logic             Snz_Limit
);

  localparam logic [CNT_W-1:0] RING_INIT = CNT_W'(RING_SECONDS);
  localparam logic [CNT_W-1:0] SNZ_INIT  = CNT_W'(SNZ_SECONDS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  if ((2 ** CNT_W) <= RING_SECONDS || (2 ** CNT_W) <= SNZ_SECONDS || MAX_SNOOZE < 0) begin : g_bad_param
    $error("alarm_timer_unit: CNT_W too small for the configured periods");
  end

  alarm_state_t     state, state_nxt;
  logic             ring_load, ring_dec, ring_zero;
  logic             snz_load, snz_dec, snz_zero;
  logic [CNT_W-1:0] ring_val, snz_val, ring_nxt, snz_nxt, snz_ld_val, secs_nxt;
  logic             snz_enter, limit_hit;

  always_comb begin
    state_nxt = state;
    ring_load = 1'b0;
    snz_load  = 1'b0;
    ring_dec  = 1'b0;
    snz_dec   = 1'b0;
    if (Reset) begin
      state_nxt = ST_IDLE;
      ring_load = 1'b1;
      snz_load  = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ring_load = 1'b1;
          snz_load  = 1'b1;
          if (EN_SNZ)       state_nxt = ST_SNOOZE;
          else if (EN_STOP) state_nxt = ST_RING;
        end
        ST_RING, ST_RING_TO: begin
          if (EN_SNZ) begin
            state_nxt = ST_SNOOZE;
            snz_load  = 1'b1;
          end else if (!EN_STOP) begin
            state_nxt = ST_IDLE;
          end else if (state == ST_RING) begin
            ring_dec = Tick;
            if (ring_zero || (Tick && ring_val == ONE)) state_nxt = ST_RING_TO;
          end
        end
        ST_SNOOZE, ST_SNZ_DONE: begin
          if (!EN_SNZ) begin
            if (EN_STOP) begin
              state_nxt = ST_RING;
              ring_load = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (state == ST_SNOOZE) begin
            snz_dec = Tick;
            if (snz_zero || (Tick && snz_val == ONE)) state_nxt = ST_SNZ_DONE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign snz_enter  = (state_nxt == ST_SNOOZE) && (state != ST_SNOOZE);
  // A limited entry loads zero so the snooze expires straight away.
  assign snz_ld_val = (snz_enter && limit_hit) ? '0 : SNZ_INIT;

  sec_down_counter #(.W(CNT_W)) u_ring_cnt (
    .clk      (Clk),
    .load     (ring_load),
    .load_val (RING_INIT),
    .dec      (ring_dec),
    .value    (ring_val),
    .zero     (ring_zero)
  );

  sec_down_counter #(.W(CNT_W)) u_snz_cnt (
    .clk      (Clk),
    .load     (snz_load),
    .load_val (snz_ld_val),
    .dec      (snz_dec),
    .value    (snz_val),
    .zero     (snz_zero)
  );

  // Post-edge counter values, so Secs_Left can be a plain register.
  assign ring_nxt = ring_load ? RING_INIT : ((ring_dec && !ring_zero) ? ring_val - ONE : ring_val);
  assign snz_nxt  = snz_load ? snz_ld_val : ((snz_dec && !snz_zero) ? snz_val - ONE : snz_val);

  always_comb begin
    secs_nxt = '0;
    unique case (state_nxt)
      ST_RING, ST_RING_TO:     secs_nxt = ring_nxt;
      ST_SNOOZE, ST_SNZ_DONE:  secs_nxt = snz_nxt;
      default:                 secs_nxt = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      C0        <= 1'b0;
      CS0       <= 1'b0;
      Secs_Left <= '0;
    end else begin
      state     <= state_nxt;
      C0        <= (state_nxt == ST_RING_TO);
      CS0       <= (state_nxt == ST_SNZ_DONE);
      Secs_Left <= secs_nxt;
    end
  end

`ifdef SNOOZE_LIMIT_EN
  localparam int             EW      = $clog2(MAX_SNOOZE + 2);
  localparam logic [EW-1:0]  ENT_MAX = EW'(MAX_SNOOZE);

  logic [EW-1:0] entries, entries_nxt;
  logic          stop_q, user_stop;

  // A falling EN_STOP outside a snooze is the user dismissing the alarm.
  assign user_stop = stop_q && !EN_STOP && !EN_SNZ;
  assign limit_hit = (entries >= ENT_MAX);

  always_comb begin
    entries_nxt = entries;
    if (user_stop) begin
      entries_nxt = '0;
    end else if (snz_enter && entries <= ENT_MAX) begin
      entries_nxt = entries + EW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stop_q    <= 1'b0;
      entries   <= '0;
      Snz_Limit <= 1'b0;
    end else begin
      stop_q    <= EN_STOP;
      entries   <= entries_nxt;
      Snz_Limit <= (entries_nxt > ENT_MAX);
    end
  end
`else
  assign limit_hit = 1'b0;
  assign Snz_Limit = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_timer_unit.sv
// Randomized and directed bench for alarm_timer_unit against a phase-level reference model.
module tb_alarm_timer_unit;

  localparam int R    = 3;
  localparam int S    = 5;
  localparam int MAXS = 2;
  localparam int W    = 9;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Tick = 1'b0;
  logic         EN_STOP = 1'b0;
  logic         EN_SNZ = 1'b0;
  logic         C0, CS0, Snz_Limit;
  logic [W-1:0] Secs_Left;

  alarm_timer_unit #(
    .RING_SECONDS (R),
    .SNZ_SECONDS  (S),
    .CNT_W        (W),
    .MAX_SNOOZE   (MAXS)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Tick      (Tick),
    .EN_STOP   (EN_STOP),
    .EN_SNZ    (EN_SNZ),
    .C0        (C0),
    .CS0       (CS0),
    .Secs_Left (Secs_Left),
    .Snz_Limit (Snz_Limit)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int tcnt = 0;

  // model: phase 0 idle, 1 ringing, 2 snoozing; age = cycles since phase entry
  int m_phase = 0, m_ring = R, m_snz = S, m_age = 0, m_entries = 0;
  bit m_prev_stop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    int np;
    if (Reset) begin
      m_phase = 0; m_ring = R; m_snz = S; m_age = 0; m_entries = 0; m_prev_stop = 0;
    end else begin
      np = EN_SNZ ? 2 : (EN_STOP ? 1 : 0);
`ifdef SNOOZE_LIMIT_EN
      if (m_prev_stop && !EN_STOP && !EN_SNZ) m_entries = 0;
`endif
      if (np != m_phase) begin
        m_age = 0;
        if (np == 1) m_ring = R;
        if (np == 2) begin
          m_snz = S;
`ifdef SNOOZE_LIMIT_EN
          if (m_entries >= MAXS) m_snz = 0;
          if (m_entries <= MAXS) m_entries++;
`endif
        end
      end else begin
        if (m_age < 1000) m_age++;
        if (Tick && np == 1 && m_ring > 0) m_ring--;
        if (Tick && np == 2 && m_snz > 0) m_snz--;
      end
      m_phase = np;
      m_prev_stop = EN_STOP;
    end
  endtask

  task automatic compare_all();
    int e_secs;
    e_secs = (m_phase == 1) ? m_ring : ((m_phase == 2) ? m_snz : 0);
    check("c0", C0, (m_phase == 1 && m_ring == 0 && m_age >= 1) ? 1 : 0);
    check("cs0", CS0, (m_phase == 2 && m_snz == 0 && m_age >= 1) ? 1 : 0);
    check("secs_left", Secs_Left, e_secs);
`ifdef SNOOZE_LIMIT_EN
    check("snz_limit", Snz_Limit, (m_entries > MAXS) ? 1 : 0);
`else
    check("snz_limit", Snz_Limit, 0);
`endif
  endtask

  // One clock: drive inputs, let the edge pass, sample 1 time unit later.
  task automatic cyc(input bit r, input bit s, input bit z);
    Reset = r; EN_STOP = s; EN_SNZ = z;
    Tick = (tcnt % 4 == 3);
    @(posedge Clk);
    #1;
    model_step();
    compare_all();
    tcnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge Clk);
    // reset held two cycles
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("rst_c0", C0, 0);
    check("rst_cs0", CS0, 0);
    check("rst_secs", Secs_Left, 0);
    check("rst_limit", Snz_Limit, 0);

    // ring to timeout, then stop
    cyc(0, 1, 0);
    check("ring_load", Secs_Left, R);
    for (int i = 0; i < 19; i++) cyc(0, 1, 0);
    check("ring_timeout_c0", C0, 1);
    cyc(0, 0, 0);
    check("stop_clears_c0", C0, 0);
    cyc(0, 0, 0);

    // ring, then snooze while still ringing, then back to ring
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    check("snz_entry_secs", Secs_Left, S);
    check("snz_entry_c0", C0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 1, 1);
    check("snz_done_cs0", CS0, 1);
    cyc(0, 1, 0);
    check("back_to_ring_secs", Secs_Left, R);
    check("back_to_ring_cs0", CS0, 0);

    // snooze entry coinciding with a Tick
    cyc(0, 0, 0);
    for (int i = 0; i < 4 && (tcnt % 4 != 3); i++) cyc(0, 0, 0);
    cyc(0, 1, 1);
    check("tick_at_entry_secs", Secs_Left, S);

    // reset in the middle of a snooze count
    for (int i = 0; i < 40 && Secs_Left != 2; i++) cyc(0, 1, 1);
    check("reach_snz_2", Secs_Left, 2);
    cyc(1, 1, 1);
    check("midrst_secs", Secs_Left, 0);
    check("midrst_cs0", CS0, 0);
    check("midrst_c0", C0, 0);
    check("midrst_limit", Snz_Limit, 0);

    // three snooze entries without a user stop
    cyc(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 1); cyc(0, 1, 1);
      cyc(0, 1, 0); cyc(0, 1, 0);
    end
    cyc(0, 1, 1);
`ifdef SNOOZE_LIMIT_EN
    check("limited_entry_secs", Secs_Left, 0);
    check("limited_entry_cs0", CS0, 0);
    check("limited_entry_flag", Snz_Limit, 1);
    cyc(0, 1, 1);
    check("limited_cs0_next", CS0, 1);
`else
    check("unlimited_entry_secs", Secs_Left, S);
    check("unlimited_flag", Snz_Limit, 0);
    cyc(0, 1, 1);
`endif
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("user_stop_limit", Snz_Limit, 0);

    // randomized long run
    begin
      bit s, z, r;
      s = 0; z = 0;
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 11) == 0) s = ~s;
        if ($urandom_range(0, 14) == 0) z = ~z;
        cyc(r, s, z);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
